// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS32 core: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, mux selects and aluop, with a watchdog on memory handshakes.
module multicycle_control #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       jrsig,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zext,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal,
    output logic       mem_err,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        BEQ_EX   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ORI_EX   = 4'd11,
        IMM_WB   = 4'd12
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    state_t        state, next_state;
    logic [CW-1:0] wd_cnt;
    logic          mem_state;
    logic          timeout;
    logic          pcwrite;
    logic          branch;

    assign mem_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    // mem_ready on the last allowed cycle completes normally, so it masks the abort
    assign timeout   = (TIMEOUT != 0) && mem_state && !mem_ready && (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Counter restarts whenever a state is entered, so it only accumulates while a memory state waits
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (timeout || (next_state != state)) begin
            wd_cnt <= '0;
        end else if (mem_state && !mem_ready) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    6'b000000: next_state = RTYPE_EX;
                    6'b100011,
                    6'b101011: next_state = MEMADR;
                    6'b000100: next_state = BEQ_EX;
                    6'b000010: next_state = JUMP;
                    6'b001000: next_state = ADDI_EX;
                    6'b001101: next_state = ORI_EX;
                    default:   next_state = FETCH;
                endcase
            end
            MEMADR:   next_state = (opcode == 6'b100011) ? MEMRD : MEMWR;
            MEMRD:    next_state = mem_ready ? MEMWB : MEMRD;
            MEMWB:    next_state = FETCH;
            MEMWR:    next_state = mem_ready ? FETCH : MEMWR;
            RTYPE_EX: next_state = jrsig ? FETCH : RTYPE_WB;
            RTYPE_WB: next_state = FETCH;
            BEQ_EX:   next_state = FETCH;
            JUMP:     next_state = FETCH;
            ADDI_EX:  next_state = IMM_WB;
            ORI_EX:   next_state = IMM_WB;
            IMM_WB:   next_state = FETCH;
            default:  next_state = FETCH;
        endcase
        if (timeout) begin
            next_state = FETCH;
        end
    end

    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        iord     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        zext     = 1'b0;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        illegal  = 1'b0;
        mem_err  = 1'b0;
        state_o  = 4'd0;
        if (!rst) begin
            state_o = state;
            case (state)
                FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                    mem_err = timeout;
                end
                DECODE: begin
                    alusrcb = 2'b11;
                    case (opcode)
                        6'b000000, 6'b100011, 6'b101011, 6'b000100,
                        6'b000010, 6'b001000, 6'b001101: illegal = 1'b0;
                        default:                         illegal = 1'b1;
                    endcase
                end
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                    mem_err = timeout;
                end
                MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                MEMWR: begin
                    memwrite = !timeout;
                    iord     = 1'b1;
                    mem_err  = timeout;
                end
                RTYPE_EX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                    if (jrsig) begin
                        pcsrc   = 2'b11;
                        pcwrite = 1'b1;
                    end
                end
                RTYPE_WB: begin
                    aluop    = 2'b10;
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                BEQ_EX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b01;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                end
                JUMP: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
                ADDI_EX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                ORI_EX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    zext    = 1'b1;
                    aluop   = 2'b11;
                end
                IMM_WB: begin
                    regwrite = 1'b1;
                end
                default: begin
                    state_o = state;
                end
            endcase
        end
        pc_en = pcwrite | (branch & zero);
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: the driver pushes the expected output word per cycle,
// and a negedge monitor pops and compares it against the DUT outputs.
module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       jrsig;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic       zext;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal, mem_err;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;
    logic [21:0] exp_q[$];
    logic [21:0] act;

    // Output word: state[21:18] pc_en iord memread memwrite irwrite memtoreg regdst regwrite
    // alusrca alusrcb[8:7] zext pcsrc[5:4] aluop[3:2] illegal mem_err
    localparam logic [21:0] PC_EN    = 22'h1 << 17;
    localparam logic [21:0] MEMWRITE = 22'h1 << 14;
    localparam logic [21:0] IRWRITE  = 22'h1 << 13;
    localparam logic [21:0] PCSRC_JR = 22'h3 << 4;
    localparam logic [21:0] ILLEGAL  = 22'h1 << 1;
    localparam logic [21:0] MEM_ERR  = 22'h1;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_BAD = 6'b111111;

    multicycle_control #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .jrsig(jrsig), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .zext(zext),
        .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal), .mem_err(mem_err),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] mk(logic [3:0] st, logic iord_e, logic memread_e,
                                       logic memwrite_e, logic memtoreg_e, logic regdst_e,
                                       logic regwrite_e, logic alusrca_e, logic [1:0] alusrcb_e,
                                       logic zext_e, logic [1:0] pcsrc_e, logic [1:0] aluop_e,
                                       logic pc_en_e);
        return {st, pc_en_e, iord_e, memread_e, memwrite_e, 1'b0, memtoreg_e, regdst_e,
                regwrite_e, alusrca_e, alusrcb_e, zext_e, pcsrc_e, aluop_e, 2'b00};
    endfunction

    // Ungated Moore outputs of each state, typed in from the state table
    function automatic logic [21:0] moore(int st);
        case (st)
            0:  return mk(4'd0,  0, 1, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0);
            1:  return mk(4'd1,  0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00, 2'b00, 0);
            2:  return mk(4'd2,  0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0);
            3:  return mk(4'd3,  1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
            4:  return mk(4'd4,  0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0);
            5:  return mk(4'd5,  1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
            6:  return mk(4'd6,  0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b10, 0);
            7:  return mk(4'd7,  0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00, 2'b10, 0);
            8:  return mk(4'd8,  0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 2'b01, 0);
            9:  return mk(4'd9,  0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 2'b00, 1);
            10: return mk(4'd10, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0);
            11: return mk(4'd11, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 2'b00, 2'b11, 0);
            12: return mk(4'd12, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0);
            default: return 22'h0;
        endcase
    endfunction

    // Drive one cycle of inputs and queue the outputs expected during that cycle
    task automatic step(input logic r, input logic [5:0] op, input logic jr, input logic z,
                        input logic mr, input logic [21:0] exp);
        rst       = r;
        opcode    = op;
        jrsig     = jr;
        zero      = z;
        mem_ready = mr;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_ok();
        step(0, OP_R, 0, 0, 1, moore(0) | PC_EN | IRWRITE);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [21:0] exp;
            exp = exp_q.pop_front();
            act = {state_o, pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
                   alusrca, alusrcb, zext, pcsrc, aluop, illegal, mem_err};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL outputs check %0d state_o=%0d: actual=%h expected=%h",
                         checks, state_o, act, exp);
            end
        end
    end

    initial begin
        rst = 1'b1; opcode = '0; jrsig = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        // Reset forces every output to zero
        step(1, OP_R, 1, 1, 1, 22'h0);
        step(1, OP_R, 1, 1, 1, 22'h0);
        // FETCH waits on memory
        step(0, OP_R, 0, 0, 0, moore(0));
        fetch_ok();
        // R-type add
        step(0, OP_R, 0, 0, 1, moore(1));
        step(0, OP_R, 0, 0, 1, moore(6));
        step(0, OP_R, 0, 0, 1, moore(7));
        fetch_ok();
        // lw with two wait cycles in MEMRD
        step(0, OP_LW, 0, 0, 1, moore(1));
        step(0, OP_LW, 0, 0, 1, moore(2));
        step(0, OP_LW, 0, 0, 0, moore(3));
        step(0, OP_LW, 0, 0, 0, moore(3));
        step(0, OP_LW, 0, 0, 1, moore(3));
        step(0, OP_LW, 0, 0, 1, moore(4));
        fetch_ok();
        // beq taken, then not taken
        step(0, OP_BEQ, 0, 1, 1, moore(1));
        step(0, OP_BEQ, 0, 1, 1, moore(8) | PC_EN);
        fetch_ok();
        step(0, OP_BEQ, 0, 0, 1, moore(1));
        step(0, OP_BEQ, 0, 0, 1, moore(8));
        fetch_ok();
        // jr redirects from RTYPE_EX with no writeback
        step(0, OP_R, 1, 0, 1, moore(1));
        step(0, OP_R, 1, 0, 1, moore(6) | PC_EN | PCSRC_JR);
        fetch_ok();
        // unsupported opcode
        step(0, OP_BAD, 0, 0, 1, moore(1) | ILLEGAL);
        fetch_ok();
        // j, addi, ori
        step(0, OP_J, 0, 0, 1, moore(1));
        step(0, OP_J, 0, 0, 1, moore(9));
        fetch_ok();
        step(0, OP_ADDI, 0, 0, 1, moore(1));
        step(0, OP_ADDI, 0, 0, 1, moore(10));
        step(0, OP_ADDI, 0, 0, 1, moore(12));
        fetch_ok();
        step(0, OP_ORI, 0, 0, 1, moore(1));
        step(0, OP_ORI, 0, 0, 1, moore(11));
        step(0, OP_ORI, 0, 0, 1, moore(12));
        fetch_ok();
        // sw watchdog abort on the 4th MEMWR cycle, then FETCH with a fresh count
        step(0, OP_SW, 0, 0, 1, moore(1));
        step(0, OP_SW, 0, 0, 1, moore(2));
        for (int i = 0; i < 3; i++) step(0, OP_SW, 0, 0, 0, moore(5));
        step(0, OP_SW, 0, 0, 0, (moore(5) & ~MEMWRITE) | MEM_ERR);
        step(0, OP_SW, 0, 0, 0, moore(0));
        fetch_ok();
        // sw where mem_ready arrives on the last allowed cycle
        step(0, OP_SW, 0, 0, 1, moore(1));
        step(0, OP_SW, 0, 0, 1, moore(2));
        for (int i = 0; i < 3; i++) step(0, OP_SW, 0, 0, 0, moore(5));
        step(0, OP_SW, 0, 0, 1, moore(5));
        // FETCH watchdog abort
        for (int i = 0; i < 3; i++) step(0, OP_R, 0, 0, 0, moore(0));
        step(0, OP_R, 0, 0, 0, moore(0) | MEM_ERR);
        step(0, OP_R, 0, 0, 0, moore(0));
        fetch_ok();
        // reset mid-instruction abandons it
        step(0, OP_R, 0, 0, 1, moore(1));
        step(1, OP_R, 0, 0, 1, 22'h0);
        step(0, OP_R, 0, 0, 0, moore(0));
        fetch_ok();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
